apb_matmul_slave: RTL
=====================

Name: apb_matmul_slave

Overview:
- APB3-style completer (slave) for the matrix engine. It terminates transfers issued by the bench stimulus or the SoC requester.
- Exposes control/status registers and a memory window that forwards operand/result accesses to the engine's matrix buffer with a one-cycle read latency.
- Generates the engine start pulse and captures the engine completion.

Parameters:
- ADDR_WIDTH, 16, APB address width (byte address).
- DATA_WIDTH, 32, APB data width; fixed at 32.
- MEM_ADDR_WIDTH, 6, word-address width of the matrix buffer window.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  1 = write.
- paddr_i  in  ADDR_WIDTH  byte address.
- pwdata_i  in  32  write data.
- pstrb_i  in  4  byte strobes.
- prdata_o  out  32  read data.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error; valid with pready_o.
- start_o  out  1  one-cycle engine start pulse.
- mode_o  out  2  engine operation select (CTRL[2:1]).
- busy_i  in  1  engine busy level.
- done_i  in  1  engine completion pulse.
- mem_req_o  out  1  buffer access strobe.
- mem_we_o  out  1  buffer write enable.
- mem_addr_o  out  MEM_ADDR_WIDTH  buffer word address.
- mem_wdata_o  out  32  buffer write data.
- mem_be_o  out  4  buffer byte enables (= pstrb_i).
- mem_rdata_i  in  32  buffer read data; valid 1 cycle after read req.

Behaviour:
- Reset values (asynchronous): all outputs 0, FSM = IDLE, CTRL.mode = 0, SCRATCH = 0, DONE = 0.
- Address map (word aligned, paddr_i[1:0] ignored):
  - 0x000 CTRL: bit0 START (write-1 pulses start_o; reads 0); bits[2:1] MODE (RW); other bits read 0.
  - 0x004 STATUS: bit0 BUSY (RO, = busy_i); bit1 DONE (sticky, W1C); other bits read 0.
  - 0x008 SCRATCH: 32-bit RW, honours pstrb_i per byte.
  - 0x100 to 0x100 + 4*2^MEM_ADDR_WIDTH - 4 MEM window: mem_addr_o = paddr_i[MEM_ADDR_WIDTH+1:2].
  - Any other address: pslverr_o = 1, read data 0, no state change.
- FSM states:
  - IDLE: waits for psel_i & !penable_i (setup) -> ACCESS.
  - ACCESS: first cycle with penable_i.
    - Register access or MEM write: pready_o = 1 this cycle, -> IDLE.
    - MEM read: mem_req_o = 1, mem_we_o = 0, pready_o = 0, -> RD_WAIT.
  - RD_WAIT: prdata_o = mem_rdata_i, pready_o = 1, -> IDLE.
  - psel_i dropping in ACCESS/RD_WAIT (protocol violation): return to IDLE, no side effects, mem_req_o not issued.
- Latency:
  - Register read/write and MEM write: 0 wait states.
  - MEM read: exactly 1 wait state.
- pready_o, pslverr_o and prdata_o are combinational from FSM state and registered/latched data. prdata_o = 0 whenever pready_o = 0.
- Side effects (START pulse, register update, DONE clear, MEM write) occur only in the completing access cycle, once per transfer.
- MEM write: mem_req_o = mem_we_o = 1 for one cycle, mem_wdata_o = pwdata_i, mem_be_o = pstrb_i.
- START:
  - Write CTRL with bit0 = 1 while busy_i = 0: start_o = 1 in the cycle after the access completes; MODE is updated in the same write.
  - If busy_i = 1: START and MODE are ignored, pslverr_o = 1.
- MEM access (read or write) while busy_i = 1: pslverr_o = 1, no mem_req_o, read data 0.
- DONE:
  - done_i = 1 sets DONE on the next edge.
  - W1C of bit1 clears it.
  - done_i in the same cycle as the clear: DONE stays 1 (set wins).
- Reset asserted mid-transfer: FSM -> IDLE immediately, pready_o drops, any pending start_o or mem_req_o is suppressed.
- Back-to-back transfers (setup in the cycle after pready_o): supported with no idle cycle required.

Test Plan:
- Reset then read STATUS with busy_i = 0 -> prdata_o = 0x0, pready_o high in first access cycle, pslverr_o = 0.
- Write SCRATCH 0xDEADBEEF, pstrb 0b0101, then read -> 0x00AD00EF.
- Write MEM 0x10C = 0x12345678, then read 0x10C with mem model returning 0x12345678 -> mem_addr_o = 3, mem_we pulse on write; read completes with exactly 1 wait state and prdata_o = 0x12345678.
- Write CTRL = 0x5 with busy_i = 0 -> single start_o pulse, mode_o = 2. Repeat with busy_i = 1 -> no pulse, pslverr_o = 1, mode_o stays 2.
- done_i pulse then STATUS read -> 0x2. Write STATUS = 0x2 with done_i asserted in the same cycle -> DONE remains 1. Write again without done_i -> read 0x0.
- Read 0x20 -> pslverr_o = 1, prdata_o = 0. Assert rst_i during a MEM read's RD_WAIT -> pready_o = 0 immediately, next transfer completes normally.

Source files
------------

// File: rtl/apb_matmul_slave.sv
// APB3 completer for the matrix engine: control/status/scratch registers plus a
// memory window onto the engine's matrix buffer (one-cycle read latency).
module apb_matmul_slave #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [ADDR_WIDTH-1:0]     paddr_i,
    input  logic [DATA_WIDTH-1:0]     pwdata_i,
    input  logic [3:0]                pstrb_i,
    output logic [DATA_WIDTH-1:0]     prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      start_o,
    output logic [1:0]                mode_o,
    input  logic                      busy_i,
    input  logic                      done_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [3:0]                mem_be_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;

    localparam logic [ADDR_WIDTH-1:0] MEM_BASE = ADDR_WIDTH'('h100);
    localparam logic [ADDR_WIDTH-1:0] MEM_LAST = ADDR_WIDTH'('h100 + 4 * (2 ** MEM_ADDR_WIDTH) - 4);

    state_t                state;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] scratch_q;
    logic                  done_q;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  sel_ctrl, sel_status, sel_scratch, sel_mem;
    logic                  access_phase, xfer_err, mem_rd, commit_wr;
    logic [DATA_WIDTH-1:0] reg_rdata;

    assign word_addr   = paddr_i & ~ADDR_WIDTH'(3);
    assign sel_ctrl    = (word_addr == '0);
    assign sel_status  = (word_addr == ADDR_WIDTH'(4));
    assign sel_scratch = (word_addr == ADDR_WIDTH'(8));
    assign sel_mem     = (word_addr >= MEM_BASE) && (word_addr <= MEM_LAST);

    // Errors: unmapped address, START while the engine runs, or any buffer access while busy.
    assign xfer_err = !(sel_ctrl || sel_status || sel_scratch || sel_mem)
                    || (sel_ctrl && pwrite_i && pwdata_i[0] && busy_i)
                    || (sel_mem && busy_i);

    assign access_phase = (state == ACCESS) && psel_i && penable_i;
    assign mem_rd       = sel_mem && !pwrite_i && !xfer_err;
    assign commit_wr    = access_phase && pwrite_i && !xfer_err;

    assign pready_o  = (access_phase && !mem_rd) || ((state == RD_WAIT) && psel_i);
    assign pslverr_o = access_phase && xfer_err;

    assign mem_req_o   = access_phase && sel_mem && !xfer_err;
    assign mem_we_o    = mem_req_o && pwrite_i;
    assign mem_addr_o  = mem_req_o ? paddr_i[MEM_ADDR_WIDTH+1:2] : '0;
    assign mem_wdata_o = mem_we_o ? pwdata_i : '0;
    assign mem_be_o    = mem_req_o ? pstrb_i : '0;
    assign mode_o      = mode_q;

    always_comb begin
        reg_rdata = '0;
        if (sel_ctrl)
            reg_rdata[2:1] = mode_q;
        else if (sel_status)
            reg_rdata[1:0] = {done_q, busy_i};
        else if (sel_scratch)
            reg_rdata = scratch_q;
    end

    always_comb begin
        prdata_o = '0;
        if ((state == RD_WAIT) && psel_i)
            prdata_o = mem_rdata_i;
        else if (access_phase && !pwrite_i && !xfer_err && !sel_mem)
            prdata_o = reg_rdata;
    end

    // Register side effects fire only in the completing access cycle; a new done_i beats a W1C.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            mode_q    <= '0;
            scratch_q <= '0;
            done_q    <= 1'b0;
            start_o   <= 1'b0;
        end else begin
            start_o <= commit_wr && sel_ctrl && pwdata_i[0];
            if (commit_wr && sel_ctrl)
                mode_q <= pwdata_i[2:1];
            if (commit_wr && sel_scratch) begin
                for (int b = 0; b < 4; b++) begin
                    if (pstrb_i[b])
                        scratch_q[8*b +: 8] <= pwdata_i[8*b +: 8];
                end
            end
            done_q <= done_i || (done_q && !(commit_wr && sel_status && pwdata_i[1]));

            case (state)
                IDLE: begin
                    if (psel_i && !penable_i)
                        state <= ACCESS;
                end
                ACCESS: begin
                    if (!psel_i)
                        state <= IDLE;
                    else if (penable_i)
                        state <= mem_rd ? RD_WAIT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
